// File: rtl/otp_macro_cmd_initiator.sv
// otp_macro_cmd_initiator
//   Requester side of the generic OTP macro command interface. Host ops are
//   encoded to sparse 7-bit macro commands, driven on a valid/ready request
//   channel, and the macro response (rdata/err) is returned to the host as a
//   one-cycle pulse. After reset the block issues Init first, latches fatal
//   errors, counts correctable ECC responses, and times out a silent macro.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   host_req_i/op/size/addr/wdata     host op request (op 0..4 legal, 5..7 illegal)
//   host_gnt_o                        op accepted this cycle (IDLE only)
//   host_rvalid_o/rdata/err           one-cycle host response
//   otp_valid_o/ready_i               macro request handshake
//   otp_cmd/size/addr/wdata_o         macro request fields
//   otp_rvalid_i/rdata/err_i          macro response
//   init_done_o                       Init finished with NoError (sticky)
//   fatal_o                           sticky fatal error
//   corr_cnt_o                        saturating count of MacroEccCorrError responses
//   dbg_state_o                       current FSM state (debug observation)
//
// Handshake: a macro request transfers on a cycle where otp_valid_o and
// otp_ready_i are both high; while valid is high and ready is low, every
// request field is held stable. otp_rvalid_i is a single-cycle response that
// is only legal while a response is awaited (INIT_WAIT / WAIT).

module otp_macro_cmd_initiator #(
  parameter int AddrWidth     = 11,
  parameter int DataWidth     = 16,
  parameter int SizeWidth     = 2,
  parameter int TimeoutCycles = 1024,
  parameter int CorrCntWidth  = 8,
  localparam int BusWidth     = DataWidth * (1 << SizeWidth)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    host_req_i,
  input  logic [2:0]              host_op_i,
  input  logic [SizeWidth-1:0]    host_size_i,
  input  logic [AddrWidth-1:0]    host_addr_i,
  input  logic [BusWidth-1:0]     host_wdata_i,
  output logic                    host_gnt_o,
  output logic                    host_rvalid_o,
  output logic [BusWidth-1:0]     host_rdata_o,
  output logic [2:0]              host_err_o,
  output logic                    otp_valid_o,
  input  logic                    otp_ready_i,
  output logic [6:0]              otp_cmd_o,
  output logic [SizeWidth-1:0]    otp_size_o,
  output logic [AddrWidth-1:0]    otp_addr_o,
  output logic [BusWidth-1:0]     otp_wdata_o,
  input  logic                    otp_rvalid_i,
  input  logic [BusWidth-1:0]     otp_rdata_i,
  input  logic [2:0]              otp_err_i,
  output logic                    init_done_o,
  output logic                    fatal_o,
  output logic [CorrCntWidth-1:0] corr_cnt_o,
  output logic [2:0]              dbg_state_o
);

  // err_e codes
  localparam logic [2:0] ErrNone      = 3'h0;
  localparam logic [2:0] ErrMacro     = 3'h1;
  localparam logic [2:0] ErrEccCorr   = 3'h2;
  localparam logic [2:0] ErrWriteBlnk = 3'h4;

  // sparse cmd_e encodings
  localparam logic [6:0] CmdInit     = 7'b0100000;
  localparam logic [6:0] CmdRead     = 7'b1111010;
  localparam logic [6:0] CmdWrite    = 7'b1001001;
  localparam logic [6:0] CmdReadRaw  = 7'b1010100;
  localparam logic [6:0] CmdWriteRaw = 7'b1100111;
  localparam logic [6:0] CmdZeroize  = 7'b0111101;

  localparam int TmoW = $clog2(TimeoutCycles + 1);

  // StReset only exists so that all outputs stay quiet for the cycle in
  // which reset is released; the FSM always moves on to StInitReq.
  typedef enum logic [2:0] {
    StReset, StInitReq, StInitWait, StIdle, StReq, StWait, StResp, StError
  } state_e;

  state_e state_q, state_d;

  logic [6:0]              cmd_q;
  logic [SizeWidth-1:0]    size_q;
  logic [AddrWidth-1:0]    addr_q;
  logic [BusWidth-1:0]     wdata_q;
  logic                    is_read_q;
  logic [BusWidth-1:0]     rsp_rdata_q;
  logic [2:0]              rsp_err_q;
  logic                    err_rsp_q, err_rsp_d;
  logic                    fatal_q, init_done_q;
  logic [CorrCntWidth-1:0] corr_q;
  logic [TmoW-1:0]         tmo_q;

  logic fatal_set, init_done_set, grant_legal, cap_rsp, cap_tmo, corr_inc;
  logic counting, tmo_expired, stray_rsp, op_legal;

  function automatic logic [6:0] encode_cmd(input logic [2:0] op);
    case (op)
      3'd0:    encode_cmd = CmdRead;
      3'd1:    encode_cmd = CmdWrite;
      3'd2:    encode_cmd = CmdReadRaw;
      3'd3:    encode_cmd = CmdWriteRaw;
      3'd4:    encode_cmd = CmdZeroize;
      default: encode_cmd = CmdInit;
    endcase
  endfunction

  assign op_legal    = (host_op_i <= 3'd4);
  assign counting    = state_q inside {StInitReq, StInitWait, StReq, StWait};
  assign tmo_expired = counting && (tmo_q == TmoW'(TimeoutCycles - 1));
  // A response is only expected while waiting; in ERROR it is simply ignored.
  assign stray_rsp   = otp_rvalid_i && !(state_q inside {StInitWait, StWait, StError});

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StReset;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    fatal_set     = 1'b0;
    init_done_set = 1'b0;
    grant_legal   = 1'b0;
    err_rsp_d     = 1'b0;
    cap_rsp       = 1'b0;
    cap_tmo       = 1'b0;
    corr_inc      = 1'b0;
    case (state_q)
      StReset: state_d = StInitReq;
      StInitReq: begin
        if (tmo_expired) begin
          state_d   = StError;
          fatal_set = 1'b1;
        end else if (otp_ready_i) begin
          state_d = StInitWait;
        end
      end
      StInitWait: begin
        if (otp_rvalid_i) begin
          if (otp_err_i == ErrNone) begin
            state_d       = StIdle;
            init_done_set = 1'b1;
          end else begin
            state_d   = StError;
            fatal_set = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d   = StError;
          fatal_set = 1'b1;
        end
      end
      StIdle: begin
        if (host_req_i) begin
          // A granted op that cannot proceed still owes the host a response.
          if (op_legal && !otp_rvalid_i) begin
            state_d     = StReq;
            grant_legal = 1'b1;
          end else begin
            err_rsp_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (tmo_expired) begin
          state_d   = StResp;
          fatal_set = 1'b1;
          cap_tmo   = 1'b1;
        end else if (otp_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // A response arriving on the expiry cycle is taken as a normal one.
        if (otp_rvalid_i) begin
          state_d = StResp;
          cap_rsp = 1'b1;
        end else if (tmo_expired) begin
          state_d   = StResp;
          fatal_set = 1'b1;
          cap_tmo   = 1'b1;
        end
      end
      StResp: begin
        if (rsp_err_q inside {ErrNone, ErrEccCorr, ErrWriteBlnk}) begin
          state_d  = StIdle;
          corr_inc = (rsp_err_q == ErrEccCorr);
        end else begin
          state_d   = StError;
          fatal_set = 1'b1;
        end
      end
      StError: err_rsp_d = host_req_i;
      default: begin
        state_d   = StError;
        fatal_set = 1'b1;
      end
    endcase
    if (stray_rsp) begin
      state_d   = StError;
      fatal_set = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    host_gnt_o    = (state_q == StIdle) && host_req_i;
    otp_valid_o   = 1'b0;
    otp_cmd_o     = CmdInit;
    otp_size_o    = '0;
    otp_addr_o    = '0;
    otp_wdata_o   = '0;
    host_rvalid_o = 1'b0;
    host_rdata_o  = '0;
    host_err_o    = ErrNone;
    case (state_q)
      StInitReq: otp_valid_o = 1'b1;
      StReq: begin
        otp_valid_o = 1'b1;
        otp_cmd_o   = cmd_q;
        otp_size_o  = size_q;
        otp_addr_o  = addr_q;
        otp_wdata_o = wdata_q;
      end
      StResp: begin
        host_rvalid_o = 1'b1;
        host_rdata_o  = rsp_rdata_q;
        host_err_o    = rsp_err_q;
      end
      default: ;
    endcase
    // Illegal-op and ERROR-state replies never coincide with StResp.
    if (err_rsp_q) begin
      host_rvalid_o = 1'b1;
      host_err_o    = ErrMacro;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q       <= CmdInit;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_read_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ErrNone;
      err_rsp_q   <= 1'b0;
      fatal_q     <= 1'b0;
      init_done_q <= 1'b0;
      corr_q      <= '0;
      tmo_q       <= '0;
    end else begin
      err_rsp_q <= err_rsp_d;
      if (grant_legal) begin
        cmd_q     <= encode_cmd(host_op_i);
        size_q    <= host_size_i;
        addr_q    <= host_addr_i;
        wdata_q   <= host_wdata_i;
        is_read_q <= (host_op_i == 3'd0) || (host_op_i == 3'd2);
      end
      if (cap_rsp) begin
        rsp_err_q   <= otp_err_i;
        // Only reads with usable data pass rdata through to the host.
        rsp_rdata_q <= (is_read_q && (otp_err_i inside {ErrNone, ErrEccCorr}))
                       ? otp_rdata_i : '0;
      end else if (cap_tmo) begin
        rsp_err_q   <= ErrMacro;
        rsp_rdata_q <= '0;
      end
      if (fatal_set)     fatal_q     <= 1'b1;
      if (init_done_set) init_done_q <= 1'b1;
      if (corr_inc && (corr_q != '1)) corr_q <= corr_q + CorrCntWidth'(1);
      // Timeout window restarts on each entry into a request state.
      if ((state_d inside {StReq, StInitReq}) && (state_d != state_q)) tmo_q <= '0;
      else if (counting) tmo_q <= tmo_q + TmoW'(1);
    end
  end

  assign init_done_o = init_done_q;
  assign fatal_o     = fatal_q;
  assign corr_cnt_o  = corr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_otp_macro_cmd_initiator.sv
module tb_otp_macro_cmd_initiator;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req;
  logic [2:0]    host_op;
  logic [1:0]    host_size;
  logic [10:0]   host_addr;
  logic [BW-1:0] host_wdata;
  logic          host_gnt_o, host_rvalid_o;
  logic [BW-1:0] host_rdata_o;
  logic [2:0]    host_err_o;
  logic          otp_valid_o;
  logic          otp_ready;
  logic [6:0]    otp_cmd_o;
  logic [1:0]    otp_size_o;
  logic [10:0]   otp_addr_o;
  logic [BW-1:0] otp_wdata_o;
  logic          otp_rvalid;
  logic [BW-1:0] otp_rdata;
  logic [2:0]    otp_err;
  logic          init_done_o, fatal_o;
  logic [7:0]    corr_cnt_o;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  otp_macro_cmd_initiator dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_op_i(host_op), .host_size_i(host_size),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .otp_valid_o(otp_valid_o), .otp_ready_i(otp_ready), .otp_cmd_o(otp_cmd_o),
    .otp_size_o(otp_size_o), .otp_addr_o(otp_addr_o), .otp_wdata_o(otp_wdata_o),
    .otp_rvalid_i(otp_rvalid), .otp_rdata_i(otp_rdata), .otp_err_i(otp_err),
    .init_done_o(init_done_o), .fatal_o(fatal_o), .corr_cnt_o(corr_cnt_o),
    .dbg_state_o(dbg_state)
  );

  function automatic logic [6:0] exp_cmd(input logic [2:0] op);
    case (op)
      3'd0:    return 7'b1111010;
      3'd1:    return 7'b1001001;
      3'd2:    return 7'b1010100;
      3'd3:    return 7'b1100111;
      3'd4:    return 7'b0111101;
      default: return 7'b0100000;
    endcase
  endfunction

  // driver: idle all inputs
  task automatic clear_inputs();
    host_req = 0; host_op = 0; host_size = 0; host_addr = 0; host_wdata = 0;
    otp_ready = 0; otp_rvalid = 0; otp_rdata = 0; otp_err = 0;
  endtask

  // driver: reset, then answer Init immediately with NoError
  task automatic do_reset_init();
    @(negedge clk); rst = 1; clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk); otp_ready = 1;
    @(negedge clk); otp_ready = 0; otp_rvalid = 1; otp_err = 0;
    @(negedge clk); otp_rvalid = 0;
  endtask

  // driver: one host op against a scripted macro; records what was observed.
  // rsp_wait < 0 means the macro never answers.
  task automatic run_op(input logic [2:0] op, input logic [1:0] size, input logic [10:0] addr,
                        input logic [BW-1:0] wdata, input int ready_wait, input int rsp_wait,
                        input logic [BW-1:0] rsp_data, input logic [2:0] rsp_err, input int budget,
                        output logic gnt, output int lat, output logic [BW-1:0] rdata,
                        output logic [2:0] err, output int stable);
    gnt = 0; lat = 0; rdata = '0; err = '0; stable = 0;
    @(negedge clk);
    host_req = 1; host_op = op; host_size = size; host_addr = addr; host_wdata = wdata;
    #1 gnt = host_gnt_o;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      host_req = 0; otp_ready = (c == 1 + ready_wait); otp_rvalid = 0;
      if (rsp_wait >= 0 && c == 2 + ready_wait + rsp_wait) begin
        otp_rvalid = 1; otp_rdata = rsp_data; otp_err = rsp_err;
      end
      #1;
      if (c <= 1 + ready_wait && otp_valid_o && otp_cmd_o == exp_cmd(op) && otp_size_o == size &&
          otp_addr_o == addr && otp_wdata_o == wdata) stable++;
      if (host_rvalid_o) begin
        lat = c; rdata = host_rdata_o; err = host_err_o;
        break;
      end
    end
    otp_ready = 0; otp_rvalid = 0; otp_rdata = '0; otp_err = '0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); host_req = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (otp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", otp_valid_o); end
    checks++; if (otp_cmd_o !== 7'b0100000) begin errors++; $display("FAIL reset_cmd: got %b want 0100000", otp_cmd_o); end
    checks++; if (host_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0b want 0", host_gnt_o); end
    checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", host_rvalid_o); end
    checks++; if ({init_done_o, fatal_o, corr_cnt_o} !== 10'd0) begin errors++; $display("FAIL reset_status: got %0b/%0b/%0d want 0/0/0", init_done_o, fatal_o, corr_cnt_o); end
    rst = 0; host_req = 0;
    @(negedge clk); #1;
    checks++; if (otp_valid_o !== 1'b1 || otp_cmd_o !== 7'b0100000 || otp_addr_o !== 11'd0 || otp_size_o !== 2'd0) begin
      errors++; $display("FAIL init_req: got valid=%0b cmd=%b addr=%h size=%0d want 1/0100000/0/0", otp_valid_o, otp_cmd_o, otp_addr_o, otp_size_o);
    end
  endtask

  task automatic test_init();
    @(negedge clk); #1;
    checks++; if (otp_valid_o !== 1'b1) begin errors++; $display("FAIL init_hold: got %0b want 1", otp_valid_o); end
    otp_ready = 1;
    @(negedge clk); otp_ready = 0; host_req = 1; #1;
    checks++; if (host_gnt_o !== 1'b0 || otp_valid_o !== 1'b0) begin errors++; $display("FAIL init_wait: got gnt=%0b valid=%0b want 0/0", host_gnt_o, otp_valid_o); end
    host_req = 0;
    repeat (2) @(negedge clk);
    @(negedge clk); otp_rvalid = 1; otp_err = 0; #1;
    checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL init_early: got %0b want 0", init_done_o); end
    @(negedge clk); otp_rvalid = 0; #1;
    checks++; if (init_done_o !== 1'b1 || fatal_o !== 1'b0) begin errors++; $display("FAIL init_done: got done=%0b fatal=%0b want 1/0", init_done_o, fatal_o); end
    checks++; if (host_gnt_o !== 1'b0 || otp_valid_o !== 1'b0 || otp_cmd_o !== 7'b0100000) begin
      errors++; $display("FAIL idle_quiet: got gnt=%0b valid=%0b cmd=%b want 0/0/0100000", host_gnt_o, otp_valid_o, otp_cmd_o);
    end
  endtask

  task automatic test_read();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    run_op(3'd0, 2'd0, 11'h010, '0, 0, 0, 64'hBEEF, 3'h0, 20, g, lat, rd, er, st);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL read_gnt: got %0b want 1", g); end
    checks++; if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++; if (rd !== 64'hBEEF || er !== 3'h0) begin errors++; $display("FAIL read_rsp: got %h/%0d want beef/0", rd, er); end
    checks++; if (st != 1) begin errors++; $display("FAIL read_req_fields: got %0d want 1", st); end
    @(negedge clk); #1;
    checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL read_pulse: got %0b want 0", host_rvalid_o); end
    run_op(3'd2, 2'd3, 11'h7FF, '0, 2, 1, 64'h0123_4567_89AB_CDEF, 3'h0, 20, g, lat, rd, er, st);
    checks++; if (lat != 6 || st != 3) begin errors++; $display("FAIL rawread_timing: got lat=%0d stable=%0d want 6/3", lat, st); end
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF || er !== 3'h0) begin errors++; $display("FAIL rawread_rsp: got %h/%0d want 0123456789abcdef/0", rd, er); end
  endtask

  task automatic test_ecc_corr();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    for (int i = 0; i < 3; i++) begin
      run_op(3'd0, 2'd1, 11'h020 + 11'(i), '0, 0, i, 64'hCAFE_0000 + 64'(i), 3'h2, 20, g, lat, rd, er, st);
      checks++; if (rd !== 64'hCAFE_0000 + 64'(i) || er !== 3'h2) begin errors++; $display("FAIL corr_rsp%0d: got %h/%0d want %h/2", i, rd, er, 64'hCAFE_0000 + 64'(i)); end
    end
    @(negedge clk); #1;
    checks++; if (corr_cnt_o !== 8'd3 || fatal_o !== 1'b0) begin errors++; $display("FAIL corr_cnt: got %0d fatal=%0b want 3/0", corr_cnt_o, fatal_o); end
  endtask

  task automatic test_write_stall();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    run_op(3'd1, 2'd1, 11'h2A5, 64'h1234_5678, 5, 0, 64'hFFFF_FFFF, 3'h0, 30, g, lat, rd, er, st);
    checks++; if (st != 6) begin errors++; $display("FAIL write_stable: got %0d want 6", st); end
    checks++; if (lat != 8) begin errors++; $display("FAIL write_latency: got %0d want 8", lat); end
    checks++; if (rd !== '0 || er !== 3'h0) begin errors++; $display("FAIL write_rsp: got %h/%0d want 0/0", rd, er); end
    run_op(3'd4, 2'd0, 11'h100, '0, 0, 0, 64'hDEAD, 3'h0, 20, g, lat, rd, er, st);
    checks++; if (st != 1 || rd !== '0 || er !== 3'h0) begin errors++; $display("FAIL zeroize: got stable=%0d rd=%h err=%0d want 1/0/0", st, rd, er); end
    run_op(3'd3, 2'd2, 11'h0F0, 64'hAAAA_5555_AAAA_5555, 1, 0, 64'h1, 3'h4, 20, g, lat, rd, er, st);
    checks++; if (st != 2 || rd !== '0 || er !== 3'h4) begin errors++; $display("FAIL blank: got stable=%0d rd=%h err=%0d want 2/0/4", st, rd, er); end
    @(negedge clk); #1;
    checks++; if (fatal_o !== 1'b0) begin errors++; $display("FAIL blank_fatal: got %0b want 0", fatal_o); end
  endtask

  task automatic test_illegal();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    @(negedge clk); host_req = 1; host_op = 3'd6; #1;
    checks++; if (host_gnt_o !== 1'b1) begin errors++; $display("FAIL illegal_gnt: got %0b want 1", host_gnt_o); end
    @(negedge clk); host_req = 0; #1;
    checks++; if (host_rvalid_o !== 1'b1 || host_err_o !== 3'h1 || host_rdata_o !== '0 || otp_valid_o !== 1'b0) begin
      errors++; $display("FAIL illegal_rsp: got rv=%0b err=%0d rd=%h valid=%0b want 1/1/0/0", host_rvalid_o, host_err_o, host_rdata_o, otp_valid_o);
    end
    run_op(3'd0, 2'd0, 11'h033, '0, 0, 0, 64'h7777, 3'h0, 20, g, lat, rd, er, st);
    checks++; if (g !== 1'b1 || rd !== 64'h7777 || er !== 3'h0 || fatal_o !== 1'b0) begin
      errors++; $display("FAIL after_illegal: got gnt=%0b rd=%h err=%0d fatal=%0b want 1/7777/0/0", g, rd, er, fatal_o);
    end
  endtask

  task automatic test_uncorr();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    int seen_valid;
    run_op(3'd1, 2'd0, 11'h044, 64'h55, 0, 0, 64'h0, 3'h3, 20, g, lat, rd, er, st);
    checks++; if (er !== 3'h3 || lat != 3) begin errors++; $display("FAIL uncorr_rsp: got err=%0d lat=%0d want 3/3", er, lat); end
    @(negedge clk); #1;
    checks++; if (fatal_o !== 1'b1) begin errors++; $display("FAIL uncorr_fatal: got %0b want 1", fatal_o); end
    host_req = 1; host_op = 3'd0; #1;
    seen_valid = int'(otp_valid_o);
    checks++; if (host_gnt_o !== 1'b0) begin errors++; $display("FAIL error_gnt: got %0b want 0", host_gnt_o); end
    @(negedge clk); host_req = 0; #1;
    seen_valid += int'(otp_valid_o);
    checks++; if (host_rvalid_o !== 1'b1 || host_err_o !== 3'h1 || host_rdata_o !== '0) begin
      errors++; $display("FAIL error_rsp: got rv=%0b err=%0d rd=%h want 1/1/0", host_rvalid_o, host_err_o, host_rdata_o);
    end
    @(negedge clk); #1;
    seen_valid += int'(otp_valid_o);
    checks++; if (seen_valid != 0 || host_rvalid_o !== 1'b0) begin errors++; $display("FAIL error_quiet: got valid_cycles=%0d rv=%0b want 0/0", seen_valid, host_rvalid_o); end
  endtask

  task automatic test_corr_saturate();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    do_reset_init();
    #1;
    checks++; if (init_done_o !== 1'b1 || fatal_o !== 1'b0 || corr_cnt_o !== 8'd0) begin
      errors++; $display("FAIL reinit: got done=%0b fatal=%0b corr=%0d want 1/0/0", init_done_o, fatal_o, corr_cnt_o);
    end
    for (int i = 0; i < 260; i++)
      run_op(3'd0, 2'd0, 11'(i), '0, 0, 0, 64'(i), 3'h2, 20, g, lat, rd, er, st);
    @(negedge clk); #1;
    checks++; if (corr_cnt_o !== 8'hFF || fatal_o !== 1'b0) begin errors++; $display("FAIL corr_sat: got %0d fatal=%0b want 255/0", corr_cnt_o, fatal_o); end
  endtask

  task automatic test_timeout();
    logic g; int lat, st; logic [BW-1:0] rd; logic [2:0] er;
    run_op(3'd0, 2'd0, 11'h055, '0, 0, -1, '0, 3'h0, 1100, g, lat, rd, er, st);
    checks++; if (lat != 1025) begin errors++; $display("FAIL timeout_latency: got %0d want 1025", lat); end
    checks++; if (er !== 3'h1 || rd !== '0 || fatal_o !== 1'b1) begin errors++; $display("FAIL timeout_rsp: got err=%0d rd=%h fatal=%0b want 1/0/1", er, rd, fatal_o); end
    @(negedge clk); host_req = 1; #1;
    checks++; if (host_gnt_o !== 1'b0 || otp_valid_o !== 1'b0) begin errors++; $display("FAIL timeout_error: got gnt=%0b valid=%0b want 0/0", host_gnt_o, otp_valid_o); end
    host_req = 0;
  endtask

  task automatic test_protocol();
    do_reset_init();
    otp_rvalid = 1; otp_rdata = 64'h99;
    @(negedge clk); otp_rvalid = 0; otp_rdata = 0; #1;
    checks++; if (fatal_o !== 1'b1 || host_rvalid_o !== 1'b0) begin errors++; $display("FAIL stray_rsp: got fatal=%0b rv=%0b want 1/0", fatal_o, host_rvalid_o); end
    host_req = 1; #1;
    checks++; if (host_gnt_o !== 1'b0) begin errors++; $display("FAIL stray_gnt: got %0b want 0", host_gnt_o); end
    host_req = 0;
  endtask

  task automatic test_reset_mid_op();
    do_reset_init();
    host_req = 1; host_op = 3'd0; host_addr = 11'h012;
    @(negedge clk); host_req = 0; #1;
    checks++; if (otp_valid_o !== 1'b1) begin errors++; $display("FAIL midop_req: got %0b want 1", otp_valid_o); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (otp_valid_o !== 1'b0 || host_rvalid_o !== 1'b0 || init_done_o !== 1'b0 || otp_cmd_o !== 7'b0100000) begin
      errors++; $display("FAIL midop_reset: got valid=%0b rv=%0b done=%0b cmd=%b want 0/0/0/0100000", otp_valid_o, host_rvalid_o, init_done_o, otp_cmd_o);
    end
    rst = 0;
    @(negedge clk); #1;
    checks++; if (host_rvalid_o !== 1'b0 || otp_valid_o !== 1'b1 || otp_cmd_o !== 7'b0100000) begin
      errors++; $display("FAIL midop_restart: got rv=%0b valid=%0b cmd=%b want 0/1/0100000", host_rvalid_o, otp_valid_o, otp_cmd_o);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_ecc_corr();
    test_write_stall();
    test_illegal();
    test_uncorr();
    test_corr_saturate();
    test_timeout();
    test_protocol();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
